// File: rtl/output_tile_writer.sv
// Drains systolic-array result vectors into the result memory one lane per cycle,
// requantizing each accumulator to int8 and laying the tile out channel-major (CHW).
module output_tile_writer #(
  parameter int ARRAYWIDTH = 8,
  parameter int ACC_W      = 32,
  parameter int NUM_PIX    = 196,
  parameter int NUM_OC     = 64,
  parameter int SHIFT      = 8,
  parameter int ADDR_W     = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        relu_en,
  input  logic                        in_valid,
  input  logic [ACC_W*ARRAYWIDTH-1:0] in_data,
  output logic                        in_ready,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [7:0]                  wr_data,
  output logic                        busy,
  output logic                        done
);

  localparam int NUM_TILES = NUM_OC / ARRAYWIDTH;
  localparam int K_W = (ARRAYWIDTH > 1) ? $clog2(ARRAYWIDTH) : 1;
  localparam int P_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam int T_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  localparam logic [K_W-1:0] K_LAST = K_W'(ARRAYWIDTH - 1);
  localparam logic [P_W-1:0] P_LAST = P_W'(NUM_PIX - 1);
  localparam logic [T_W-1:0] T_LAST = T_W'(NUM_TILES - 1);

  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-128);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                      state;
  logic                        hv;
  logic                        relu_q;
  logic [K_W-1:0]              k;
  logic [P_W-1:0]              p;
  logic [T_W-1:0]              t;
  logic [ACC_W*ARRAYWIDTH-1:0] hold_data;

  logic                        last_lane;
  logic                        last_elem;
  logic                        accept;
  logic signed [ACC_W-1:0]     lane;
  logic signed [ACC_W-1:0]     shifted;
  logic [7:0]                  q;

  assign last_lane = hv && (k == K_LAST);
  assign last_elem = last_lane && (p == P_LAST) && (t == T_LAST);

  // The slot frees up on the last lane, except after the layer's final element.
  assign in_ready = (state == RUN) && (!hv || (last_lane && !last_elem));
  assign accept   = in_valid && in_ready;

  // NOTE: the holding register is qualified by hv, so it is pure datapath and carries no reset.
  always_ff @(posedge clk) begin
    if (accept) hold_data <= in_data;
  end

  // NOTE: combinational blocks use blocking '=' with every output defaulted first,
  // so each value is computed in order and no latch is inferred.
  always_comb begin
    lane    = $signed(hold_data[k*ACC_W +: ACC_W]);
    shifted = lane >>> SHIFT;
    if (relu_q && shifted[ACC_W-1]) shifted = '0;
    if (shifted > Q_MAX)      q = 8'h7f;
    else if (shifted < Q_MIN) q = 8'h80;
    else                      q = shifted[7:0];
  end

  assign wr_en   = hv;
  assign wr_data = hv ? q : 8'h00;
  assign wr_addr = hv ? ADDR_W'((ADDR_W'(t) * ADDR_W'(ARRAYWIDTH) + ADDR_W'(k)) * ADDR_W'(NUM_PIX)
                                + ADDR_W'(p))
                      : '0;

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      hv     <= 1'b0;
      relu_q <= 1'b0;
      k      <= '0;
      p      <= '0;
      t      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            hv     <= 1'b0;
            relu_q <= relu_en;
            k      <= '0;
            p      <= '0;
            t      <= '0;
          end
        end
        RUN: begin
          if (last_elem) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            hv    <= 1'b0;
          end else begin
            if (hv && !last_lane) k <= k + 1'b1;
            if (last_lane) begin
              if (p == P_LAST) begin
                p <= '0;
                t <= t + 1'b1;
              end else begin
                p <= p + 1'b1;
              end
            end
            // A vector accepted on the last lane keeps the pipe full with no bubble.
            if (accept) begin
              hv <= 1'b1;
              k  <= '0;
            end else if (last_lane) begin
              hv <= 1'b0;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_tile_writer.sv
// Scoreboard bench for output_tile_writer: the driver queues expected writes on acceptance,
// a negedge monitor pops and compares every wr_en strobe.
module tb_output_tile_writer;

  localparam int AW     = 8;
  localparam int ACC_W  = 32;
  localparam int NP     = 4;
  localparam int NOC    = 16;
  localparam int SH     = 8;
  localparam int ADDR_W = 14;
  localparam int NV     = NP * NOC / AW;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  relu_en;
  logic                  in_valid;
  logic [ACC_W*AW-1:0]   in_data;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [7:0]            wr_data;
  logic                  busy;
  logic                  done;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } exp_t;

  exp_t exp_q[$];

  int n_checks   = 0;
  int n_pass     = 0;
  int cyc        = 0;
  int wr_count   = 0;
  int first_wr   = -1;
  int last_wr    = -1;
  int done_count = 0;
  int done_cyc   = -1;
  int hit[64];

  output_tile_writer #(
    .ARRAYWIDTH(AW), .ACC_W(ACC_W), .NUM_PIX(NP), .NUM_OC(NOC), .SHIFT(SH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Directed lane values; most lanes encode (v*8+l) in the integer part so results are obvious.
  function automatic logic [31:0] lane_val(input int v, input int l);
    if (v == 0 && l == 0) return 32'hFFFF0000;
    if (v == 0 && l == 1) return 32'h00100000;
    if (v == 0 && l == 3) return 32'h00000500;
    if (v == 1 && l == 0) return 32'hFFFF8000;
    if (v == 1 && l == 1) return 32'h00008000;
    if (l == 2)           return 32'(-((v + 1) * 256 + 128));
    return 32'((v * 8 + l) << 8);
  endfunction

  function automatic logic [7:0] exp_data(input int v, input int l, input bit relu);
    if (v == 0 && l == 0) return relu ? 8'h00 : 8'h80;
    if (v == 0 && l == 1) return 8'h7F;
    if (v == 0 && l == 3) return 8'h05;
    if (v == 1 && l == 0) return relu ? 8'h00 : 8'h80;
    if (v == 1 && l == 1) return 8'h7F;
    if (l == 2)           return relu ? 8'h00 : 8'(-(v + 2));
    return 8'(v * 8 + l);
  endfunction

  function automatic int exp_addr(input int v, input int l);
    return ((v / NP) * AW + l) * NP + (v % NP);
  endfunction

  always @(negedge clk) begin
    if (wr_en) begin
      wr_count++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (wr_addr < 64) hit[wr_addr]++;
      if (wr_addr == 14'd63) check("ready_on_final_write", in_ready, 0);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", wr_addr, wr_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
      end
    end
    if (done) begin
      done_count++;
      done_cyc = cyc;
      check("busy_in_done", busy, 0);
    end
  end

  task automatic clear_stats();
    wr_count   = 0;
    first_wr   = -1;
    last_wr    = -1;
    done_count = 0;
    done_cyc   = -1;
    for (int i = 0; i < 64; i++) hit[i] = 0;
  endtask

  task automatic do_start(input bit relu);
    start   = 1'b1;
    relu_en = relu;
    @(posedge clk); #1;
    start   = 1'b0;
    relu_en = ~relu;
    check("busy_after_start", busy, 1);
  endtask

  task automatic send(input int v, input bit relu);
    int n = 0;
    for (int l = 0; l < AW; l++) in_data[l*ACC_W +: ACC_W] = lane_val(v, l);
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_timeout", in_ready, 1);
    for (int l = 0; l < AW; l++)
      exp_q.push_back('{addr: ADDR_W'(exp_addr(v, l)), data: exp_data(v, l, relu)});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_count == 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_summary(input string tag, input bit contiguous);
    int once = 0;
    check({tag, "_writes"}, wr_count, 64);
    check({tag, "_done_pulses"}, done_count, 1);
    check({tag, "_done_timing"}, done_cyc, last_wr + 1);
    if (contiguous) check({tag, "_span"}, last_wr - first_wr, 63);
    else            check({tag, "_span_has_gaps"}, (last_wr - first_wr) > 63, 1);
    for (int i = 0; i < 64; i++) if (hit[i] == 1) once++;
    check({tag, "_addrs_once"}, once, 64);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
    check({tag, "_idle_after"}, busy, 0);
  endtask

  initial begin
    int n;
    int base;
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; in_valid = 1'b0; in_data = '0;
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // in_valid while idle must be ignored
    in_valid = 1'b1;
    in_data  = '1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_in_ready", in_ready, 0);
    check("idle_busy", busy, 0);
    in_valid = 1'b0;

    // Back-to-back layer, no ReLU; an extra vector offered afterwards must never be taken
    clear_stats();
    do_start(1'b0);
    for (int v = 0; v < NV; v++) send(v, 1'b0);
    in_valid = 1'b1;
    in_data  = '1;
    wait_done();
    in_valid = 1'b0;
    run_summary("b2b", 1'b1);

    // ReLU layer with 3-cycle valid gaps and a stray start mid-run
    clear_stats();
    do_start(1'b1);
    for (int v = 0; v < NV; v++) begin
      if (v > 0) begin
        wait_ready();
        for (int g = 0; g < 3; g++) begin
          if (v == 4 && g == 0) begin
            start   = 1'b1;
            relu_en = 1'b0;
          end
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
      send(v, 1'b1);
    end
    wait_done();
    run_summary("gap", 1'b0);

    // Reset mid-layer after the 20th write, then a clean rerun
    clear_stats();
    do_start(1'b0);
    for (int v = 0; v < 3; v++) send(v, 1'b0);
    n = 0;
    while (wr_count < 20 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("rst_point_reached", wr_count >= 20, 1);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_wr_en", wr_en, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_wr_addr", wr_addr, 0);
    check("midrst_wr_data", wr_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    exp_q.delete();
    rst  = 1'b0;
    base = wr_count;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_writes", wr_count - base, 0);
    check("post_rst_done", done_count, 0);

    clear_stats();
    do_start(1'b0);
    for (int v = 0; v < NV; v++) send(v, 1'b0);
    wait_done();
    run_summary("rerun", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/output_tile_writer.md
OUTPUT_TILE_WRITER -- requirements
Module: output_tile_writer

Interface
REQ-001 SHALL have parameter ARRAYWIDTH, default 8, the number of systolic-array output lanes per result vector.
REQ-002 SHALL have parameter ACC_W, default 32, the accumulator lane width (output-buffer datasize).
REQ-003 SHALL have parameter NUM_PIX, default 196, the output pixels per channel (14x14).
REQ-004 SHALL have parameter NUM_OC, default 64, the output channels; it is constrained to a multiple of ARRAYWIDTH.
REQ-005 SHALL have parameter SHIFT, default 8, the requantization right-shift amount.
REQ-006 SHALL have parameter ADDR_W, default 14, the result-memory address width.
REQ-007 SHALL have port clk, input, 1 bit: the clock; all logic is rising-edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port start, input, 1 bit: a one-cycle request to begin a layer write-back.
REQ-010 SHALL have port relu_en, input, 1 bit: ReLU select, sampled only on an accepted start.
REQ-011 SHALL have port in_valid, input, 1 bit: result vector valid.
REQ-012 SHALL have port in_data, input, ACC_W*ARRAYWIDTH bits: result vector; lane k is at [k*ACC_W +: ACC_W], signed.
REQ-013 SHALL have port in_ready, output, 1 bit: the writer accepts in_data this cycle.
REQ-014 SHALL have port wr_en, output, 1 bit: result-memory write strobe.
REQ-015 SHALL have port wr_addr, output, ADDR_W bits: result-memory address.
REQ-016 SHALL have port wr_data, output, 8 bits: requantized signed result.
REQ-017 SHALL have port busy, output, 1 bit: high while the FSM is in RUN.
REQ-018 SHALL have port done, output, 1 bit: one-cycle pulse when the final element has been written.

Function
REQ-019 SHALL implement the FSM states IDLE, RUN and DONE; start in IDLE moves to RUN and clears the pixel counter p, tile counter t and lane counter k, and latches relu_en.
REQ-020 SHALL ignore start while in RUN or DONE.
REQ-021 SHALL hold in_ready at 0 in IDLE and DONE; in_valid in those states has no effect.
REQ-022 SHALL hold one result vector in a holding register with a valid flag hv; in RUN, in_ready = !hv | (hv & k==ARRAYWIDTH-1).
REQ-023 SHALL, on acceptance (in_valid & in_ready at a clock edge), load the holding register, set hv and set k=0; the first write (lane 0) occurs in the following cycle.
REQ-024 SHALL, while hv=1, drive wr_en=1 for exactly one lane per cycle, lane k then k+1, up to ARRAYWIDTH-1 -- ARRAYWIDTH consecutive cycles per vector with no bubbles.
REQ-025 SHALL set wr_addr = (t*ARRAYWIDTH + k)*NUM_PIX + p (channel-major CHW), truncated to ADDR_W.
REQ-026 SHALL compute wr_data as: y = lane >>> SHIFT (arithmetic); if relu latched and y<0 then y=0; saturate y to [-128,127].
REQ-027 SHALL, on the lane ARRAYWIDTH-1 write: clear hv unless a new vector is accepted in the same cycle (accept wins, hv stays 1); increment p.
REQ-028 SHALL, at p == NUM_PIX-1 with lane ARRAYWIDTH-1 written, set p=0 and increment t.
REQ-029 SHALL, after the last lane of p=NUM_PIX-1 of t=NUM_OC/ARRAYWIDTH-1, go to DONE, hold in_ready=0 that cycle, and never accept a further vector.
REQ-030 SHALL assert done for exactly one cycle in DONE and then return to IDLE; busy=0 in DONE.
REQ-031 SHALL, when in_valid is low and hv=0 in RUN, keep wr_en=0 and hold all counters.

Reset
REQ-032 SHALL, while rst=1 at a clock edge, force state=IDLE, p=t=k=0, hv=0, relu latch=0, and outputs in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
REQ-033 SHALL abandon any in-progress vector on a mid-operation reset, with no further writes and no done pulse.

Verification (bench parameters NUM_PIX=4, NUM_OC=16, ARRAYWIDTH=8, SHIFT=8)
REQ-034 SHALL cover: start, then 8 back-to-back vectors -> exactly 64 writes in 64 consecutive cycles, each address hit once over 0..63, done one cycle after the final write.
REQ-035 SHALL cover: vector 0, lane 3 = 0x00000500 -> wr_addr=12, wr_data=0x05; with p=2, t=1, k=0 -> wr_addr=34.
REQ-036 SHALL cover: lane = 0xFFFF0000 (relu=0) -> wr_data=0x80; relu=1 -> 0x00; lane = 0x00100000 -> 0x7F.
REQ-037 SHALL cover: in_valid gaps of 3 cycles between vectors -> wr_en low during the gaps, addresses unchanged versus the back-to-back run.
REQ-038 SHALL cover: rst asserted at write 20 -> outputs zero next cycle, no done; a new start then rewrites from address 0.
REQ-039 SHALL cover: start pulsed mid-RUN -> ignored, counters continue.
